// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART blocks: parity modes, receiver
// state encoding and the helpers that size the baud divider and counters.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } uart_state_e;

    function automatic int calc_div(input int clk_freq, input int bps, input int osr);
        return clk_freq / (bps * osr);
    endfunction

    // Width of a counter that spans 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks while enabled,
// counter held at zero while disabled so every enable starts a fresh period.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200,
    parameter int OSR      = 16
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int DIV   = calc_div(CLK_FREQ, UART_BPS, OSR);
    localparam int DIV_W = cnt_w(DIV);

    if (DIV < 2) begin : g_div_check
        $error("uart_baud_tick: divider %0d is below 2", DIV);
    end

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             last;

    assign last   = (cnt_q == DIV_W'(DIV - 1));
    assign tick_o = en_i && last;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en_i || last) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (data width, parity, stop bits) with framing,
// parity and break detection. Define UART_RX_MAJORITY_EN for 2-of-3 bit voting.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int UART_BPS  = 115200,
    parameter int OSR       = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] po_data,
    output logic                 po_flag,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int OS_W  = cnt_w(OSR);
    localparam int BIT_W = cnt_w(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
    localparam int SP = OSR / 2 + 1;
`else
    localparam int SP = OSR / 2;
`endif

    if (OSR < 8 || OSR % 2 != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
        $error("uart_rx_cfg: unsupported parameter combination");
    end

    uart_state_e          state_q;
    logic                 rx_meta_q, rx_s_q, rx_prev_q;
    logic [OS_W-1:0]      os_cnt_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic                 stop_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q, stop0_q;
    logic                 tick, samp_evt, wrap, bit_val;
    logic                 last_stop, first_stop, fe_d, pe_d, brk_d;

    uart_baud_tick #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS),
        .OSR      (OSR)
    ) u_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en_i      (state_q != ST_IDLE),
        .tick_o    (tick)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign samp_evt = tick && (os_cnt_q == OS_W'(SP));
    assign wrap     = tick && (os_cnt_q == OS_W'(OSR - 1));

`ifdef UART_RX_MAJORITY_EN
    // Two early samples are held; the third is the live value at the decision tick.
    logic [1:0] maj_q;
    always_ff @(posedge sys_clk) begin
        if (tick && os_cnt_q == OS_W'(SP - 2)) maj_q[0] <= rx_s_q;
        if (tick && os_cnt_q == OS_W'(SP - 1)) maj_q[1] <= rx_s_q;
    end
    assign bit_val = (maj_q[0] & maj_q[1]) | (maj_q[0] & rx_s_q) | (maj_q[1] & rx_s_q);
`else
    assign bit_val = rx_s_q;
`endif

    always_ff @(posedge sys_clk) begin
        if (samp_evt) begin
            case (state_q)
                ST_DATA:   shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
                ST_PARITY: par_q   <= bit_val;
                ST_STOP:   if (!stop_idx_q) stop0_q <= bit_val;
                default: ;
            endcase
        end
    end

    // With one stop bit the final sample is also the first one.
    assign last_stop  = (STOP_BITS == 1) || stop_idx_q;
    assign first_stop = stop_idx_q ? stop0_q : bit_val;
    assign fe_d       = !first_stop || !bit_val;
    assign pe_d       = (PARITY == PARITY_ODD)  ? !(^shift_q ^ par_q) :
                        (PARITY == PARITY_EVEN) ?  (^shift_q ^ par_q) : 1'b0;
    assign brk_d      = (shift_q == '0) && ((PARITY == PARITY_NONE) || !par_q) && !first_stop;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            stop_idx_q <= 1'b0;
            po_data    <= '0;
            po_flag    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            break_det  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            po_flag   <= 1'b0;
            break_det <= 1'b0;
            if (tick) os_cnt_q <= wrap ? '0 : os_cnt_q + 1'b1;
            case (state_q)
                ST_IDLE: begin
                    os_cnt_q   <= '0;
                    bit_cnt_q  <= '0;
                    stop_idx_q <= 1'b0;
                    if (rx_prev_q && !rx_s_q) state_q <= ST_START;
                end
                ST_START: begin
                    if (samp_evt) begin
                        if (bit_val) state_q <= ST_IDLE;
                        else         busy    <= 1'b1;
                    end
                    if (wrap) state_q <= ST_DATA;
                end
                ST_DATA: begin
                    if (wrap) begin
                        if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                            bit_cnt_q <= '0;
                            state_q   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (wrap) state_q <= ST_STOP;
                end
                ST_STOP: begin
                    if (samp_evt && last_stop) begin
                        if (brk_d) begin
                            break_det <= 1'b1;
                            frame_err <= 1'b1;
                        end else begin
                            po_flag    <= 1'b1;
                            po_data    <= shift_q;
                            frame_err  <= fe_d;
                            parity_err <= pe_d;
                        end
                        if (!bit_val) begin
                            state_q <= ST_WAIT_IDLE;
                        end else begin
                            state_q <= ST_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    if (wrap) stop_idx_q <= 1'b1;
                end
                ST_WAIT_IDLE: begin
                    if (rx_s_q) begin
                        state_q <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three receiver configurations (8N1, 8E1, 7N2)
// driven with table-driven frames plus hand-written break/glitch/reset sequences.
module tb_uart_rx_cfg;

    localparam int CLK_FREQ = 16_000_000;
    localparam int UART_BPS = 250_000;
    localparam int OSR      = 16;
    localparam int BIT_CLKS = 64;
`ifdef UART_RX_MAJORITY_EN
    localparam logic [8:0] GLITCH_EXP = 9'h02A;
`else
    localparam logic [8:0] GLITCH_EXP = 9'h022;
`endif

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;
    logic [7:0] po_data_a, po_data_b;
    logic [6:0] po_data_c;
    logic       po_flag_a, frame_err_a, parity_err_a, break_det_a, busy_a;
    logic       po_flag_b, frame_err_b, parity_err_b, break_det_b, busy_b;
    logic       po_flag_c, frame_err_c, parity_err_c, break_det_c, busy_c;

    always #5 sys_clk = ~sys_clk;

    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .OSR(OSR),
                  .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx_a), .po_data(po_data_a),
        .po_flag(po_flag_a), .frame_err(frame_err_a), .parity_err(parity_err_a),
        .break_det(break_det_a), .busy(busy_a));

    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .OSR(OSR),
                  .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx_b), .po_data(po_data_b),
        .po_flag(po_flag_b), .frame_err(frame_err_b), .parity_err(parity_err_b),
        .break_det(break_det_b), .busy(busy_b));

    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .OSR(OSR),
                  .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_c (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx(rx_c), .po_data(po_data_c),
        .po_flag(po_flag_c), .frame_err(frame_err_c), .parity_err(parity_err_c),
        .break_det(break_det_c), .busy(busy_c));

    int         flag_cnt_a = 0, flag_cnt_b = 0, flag_cnt_c = 0;
    int         brk_cnt_a = 0, busy_cyc_a = 0;
    logic [7:0] log_a [16];

    always @(posedge sys_clk) begin
        if (po_flag_a) begin
            log_a[flag_cnt_a[3:0]] <= po_data_a;
            flag_cnt_a <= flag_cnt_a + 1;
        end
        if (po_flag_b)   flag_cnt_b <= flag_cnt_b + 1;
        if (po_flag_c)   flag_cnt_c <= flag_cnt_c + 1;
        if (break_det_a) brk_cnt_a  <= brk_cnt_a + 1;
        if (busy_a)      busy_cyc_a <= busy_cyc_a + 1;
    end

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_rx(input int inst, input logic v);
        case (inst)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic hold(input int inst, input logic v, input int clks);
        set_rx(inst, v);
        repeat (clks) @(negedge sys_clk);
    endtask

    // stops[0] is the first stop bit on the line; glitch_bit < 0 means no glitch.
    task automatic send_frame(input int inst, input logic [8:0] data, input int nbits,
                              input bit has_par, input logic par, input int nstop,
                              input logic [1:0] stops, input int glitch_bit);
        hold(inst, 1'b0, BIT_CLKS);
        for (int i = 0; i < nbits; i++) begin
            if (i == glitch_bit) begin
                hold(inst, data[i], 34);
                hold(inst, ~data[i], 4);
                hold(inst, data[i], 26);
            end else begin
                hold(inst, data[i], BIT_CLKS);
            end
        end
        if (has_par) hold(inst, par, BIT_CLKS);
        for (int i = 0; i < nstop; i++) hold(inst, stops[i], BIT_CLKS);
        set_rx(inst, 1'b1);
    endtask

    function automatic int get_flags(input int inst);
        case (inst)
            0:       return flag_cnt_a;
            1:       return flag_cnt_b;
            default: return flag_cnt_c;
        endcase
    endfunction

    function automatic logic [8:0] get_data(input int inst);
        case (inst)
            0:       return {1'b0, po_data_a};
            1:       return {1'b0, po_data_b};
            default: return {2'b0, po_data_c};
        endcase
    endfunction

    function automatic logic get_fe(input int inst);
        case (inst)
            0:       return frame_err_a;
            1:       return frame_err_b;
            default: return frame_err_c;
        endcase
    endfunction

    function automatic logic get_pe(input int inst);
        case (inst)
            0:       return parity_err_a;
            1:       return parity_err_b;
            default: return parity_err_c;
        endcase
    endfunction

    typedef struct {
        int         inst;
        logic [8:0] data;
        int         nbits;
        bit         has_par;
        logic       par;
        int         nstop;
        logic [1:0] stops;
        logic [8:0] exp_data;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    initial begin
        int f0, b0, busy0;

        vecs[0] = '{0, 9'h03C, 8, 1'b0, 1'b0, 1, 2'b00, 9'h03C, 1'b1, 1'b0};
        vecs[1] = '{0, 9'h081, 8, 1'b0, 1'b0, 1, 2'b01, 9'h081, 1'b0, 1'b0};
        vecs[2] = '{1, 9'h0A3, 8, 1'b1, 1'b1, 1, 2'b01, 9'h0A3, 1'b0, 1'b1};
        vecs[3] = '{1, 9'h0A3, 8, 1'b1, 1'b0, 1, 2'b01, 9'h0A3, 1'b0, 1'b0};
        vecs[4] = '{1, 9'h007, 8, 1'b1, 1'b1, 1, 2'b01, 9'h007, 1'b0, 1'b0};
        vecs[5] = '{1, 9'h007, 8, 1'b1, 1'b0, 1, 2'b01, 9'h007, 1'b0, 1'b1};
        vecs[6] = '{1, 9'h000, 8, 1'b1, 1'b0, 1, 2'b01, 9'h000, 1'b0, 1'b0};
        vecs[7] = '{2, 9'h015, 7, 1'b0, 1'b0, 2, 2'b11, 9'h015, 1'b0, 1'b0};
        vecs[8] = '{2, 9'h06B, 7, 1'b0, 1'b0, 2, 2'b10, 9'h06B, 1'b1, 1'b0};
        vecs[9] = '{2, 9'h07F, 7, 1'b0, 1'b0, 2, 2'b11, 9'h07F, 1'b0, 1'b0};

        repeat (4) @(negedge sys_clk);
        check("rst po_data", {24'h0, po_data_a}, 32'h0);
        check("rst po_flag", {31'h0, po_flag_a}, 32'h0);
        check("rst frame_err", {31'h0, frame_err_a}, 32'h0);
        check("rst parity_err", {31'h0, parity_err_a}, 32'h0);
        check("rst break_det", {31'h0, break_det_a}, 32'h0);
        check("rst busy", {31'h0, busy_a}, 32'h0);
        sys_rst_n = 1'b1;
        repeat (8) @(negedge sys_clk);

        // Back-to-back 0x55 / 0xA3 with no idle time between frames.
        f0 = flag_cnt_a;
        send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 2'b01, -1);
        fork
            send_frame(0, 9'h0A3, 8, 1'b0, 1'b0, 1, 2'b01, -1);
            begin
                repeat (5 * BIT_CLKS) @(negedge sys_clk);
                check("b2b busy mid frame2", {31'h0, busy_a}, 32'h1);
            end
        join
        repeat (2 * BIT_CLKS) @(negedge sys_clk);
        check("b2b flag count", flag_cnt_a - f0, 2);
        check("b2b data0", {24'h0, log_a[f0[3:0]]}, 32'h55);
        check("b2b data1", {24'h0, log_a[4'(f0 + 1)]}, 32'hA3);
        check("b2b frame_err", {31'h0, frame_err_a}, 32'h0);
        check("b2b busy idle", {31'h0, busy_a}, 32'h0);

        for (int v = 0; v < NV; v++) begin
            f0 = get_flags(vecs[v].inst);
            send_frame(vecs[v].inst, vecs[v].data, vecs[v].nbits, vecs[v].has_par, vecs[v].par,
                       vecs[v].nstop, vecs[v].stops, -1);
            repeat (2 * BIT_CLKS) @(negedge sys_clk);
            check($sformatf("vec%0d flag", v), get_flags(vecs[v].inst), f0 + 1);
            check($sformatf("vec%0d data", v), {23'h0, get_data(vecs[v].inst)}, {23'h0, vecs[v].exp_data});
            check($sformatf("vec%0d frame_err", v), {31'h0, get_fe(vecs[v].inst)}, {31'h0, vecs[v].exp_fe});
            check($sformatf("vec%0d parity_err", v), {31'h0, get_pe(vecs[v].inst)}, {31'h0, vecs[v].exp_pe});
        end

        // Line held low for three frame times, then a clean 0x7E.
        f0 = flag_cnt_a;
        b0 = brk_cnt_a;
        hold(0, 1'b0, 30 * BIT_CLKS);
        check("break pulses", brk_cnt_a - b0, 1);
        check("break no flag", flag_cnt_a - f0, 0);
        check("break frame_err", {31'h0, frame_err_a}, 32'h1);
        check("break po_data held", {24'h0, po_data_a}, 32'h81);
        hold(0, 1'b1, 2 * BIT_CLKS);
        send_frame(0, 9'h07E, 8, 1'b0, 1'b0, 1, 2'b01, -1);
        repeat (2 * BIT_CLKS) @(negedge sys_clk);
        check("post-break flag", flag_cnt_a - f0, 1);
        check("post-break data", {24'h0, po_data_a}, 32'h7E);
        check("post-break frame_err", {31'h0, frame_err_a}, 32'h0);
        check("post-break pulses", brk_cnt_a - b0, 1);

        // Low pulse of OSR/4 ticks must be rejected as a false start.
        f0 = flag_cnt_a;
        busy0 = busy_cyc_a;
        hold(0, 1'b0, (OSR / 4) * (BIT_CLKS / OSR));
        hold(0, 1'b1, 12 * BIT_CLKS);
        check("false start flag", flag_cnt_a - f0, 0);
        check("false start busy cycles", busy_cyc_a - busy0, 0);
        send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 2'b01, -1);
        repeat (2 * BIT_CLKS) @(negedge sys_clk);
        check("after false start flag", flag_cnt_a - f0, 1);
        check("after false start data", {24'h0, po_data_a}, 32'h5A);

        // 7N2: glitch in the middle of data bit 3, second stop bit low.
        f0 = flag_cnt_c;
        send_frame(2, 9'h02A, 7, 1'b0, 1'b0, 2, 2'b01, 3);
        repeat (2 * BIT_CLKS) @(negedge sys_clk);
        check("glitch flag", flag_cnt_c - f0, 1);
        check("glitch data", {23'h0, get_data(2)}, {23'h0, GLITCH_EXP});
        check("glitch frame_err", {31'h0, frame_err_c}, 32'h1);

        // Reset in the middle of a frame aborts it without a strobe.
        f0 = flag_cnt_a;
        hold(0, 1'b0, 200);
        check("midframe busy", {31'h0, busy_a}, 32'h1);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("midframe reset busy", {31'h0, busy_a}, 32'h0);
        hold(0, 1'b1, 2);
        sys_rst_n = 1'b1;
        repeat (12 * BIT_CLKS) @(negedge sys_clk);
        check("midframe no flag", flag_cnt_a - f0, 0);
        check("midframe po_data reset", {24'h0, po_data_a}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
